// File: rtl/snake_dir_ctrl_if.sv
// snake_dir_ctrl_if: key/tick inputs and heading/pulse outputs
// of the snake direction controller.
interface snake_dir_ctrl_if #(
  parameter int CW = 2
);
  logic          key_valid;
  logic [7:0]    key_code;
  logic          move_tick;
  logic          init;
  logic [1:0]    dir;
  logic [CW-1:0] turn_count;
  logic          start_pulse;
  logic          pause_pulse;
  logic          drop_pulse;

  modport master (
    output key_valid, key_code, move_tick, init,
    input  dir, turn_count,
    input  start_pulse, pause_pulse, drop_pulse
  );

  modport slave (
    input  key_valid, key_code, move_tick, init,
    output dir, turn_count,
    output start_pulse, pause_pulse, drop_pulse
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: PS/2 scan codes to snake heading with a
// reversal-safe turn queue, plus start/pause pulses.
module snake_dir_ctrl #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic             clk,
  input logic             rst_n,
  snake_dir_ctrl_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EBRK
  } st_t;

  st_t r_st;
  st_t w_st_nx;
  logic w_act;

  logic       w_arrow;
  logic [1:0] w_d;
  logic       w_start;
  logic       w_pause;

  logic [1:0]    r_q [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_tail;
  logic [1:0]    r_dir;
  logic          r_start;
  logic          r_pause;
  logic          r_drop;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st <= S_IDLE;
    end else if (bus.init) begin
      r_st <= S_IDLE;
    end else begin
      r_st <= w_st_nx;
    end
  end

  always_comb begin
    w_st_nx = r_st;
    w_act   = 1'b0;
    if (bus.key_valid) begin
      unique case (r_st)
        S_IDLE: begin
          if (bus.key_code == 8'hE0) begin
            w_st_nx = S_EXT;
          end else if (bus.key_code == 8'hF0) begin
            w_st_nx = S_BRK;
          end else begin
            w_act = 1'b1;
          end
        end
        S_EXT: begin
          if (bus.key_code == 8'hF0) begin
            w_st_nx = S_EBRK;
          end else begin
            w_act   = 1'b1;
            w_st_nx = S_IDLE;
          end
        end
        S_BRK:   w_st_nx = S_IDLE;
        S_EBRK:  w_st_nx = S_IDLE;
        default: w_st_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_arrow = 1'b0;
    w_d     = 2'b00;
    w_start = 1'b0;
    w_pause = 1'b0;
    if (w_act) begin
      unique case (1'b1)
        (bus.key_code == 8'h74): begin
          w_arrow = 1'b1;
          w_d     = 2'b00;
        end
        (bus.key_code == 8'h6B): begin
          w_arrow = 1'b1;
          w_d     = 2'b01;
        end
        (bus.key_code == 8'h72): begin
          w_arrow = 1'b1;
          w_d     = 2'b10;
        end
        (bus.key_code == 8'h75): begin
          w_arrow = 1'b1;
          w_d     = 2'b11;
        end
        (bus.key_code == 8'h5A): w_start = 1'b1;
        (bus.key_code == 8'h29): w_pause = 1'b1;
        default: ;
      endcase
    end
  end

  // Checking against tail_dir lets a chain like right->up->left queue.
  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_pop  = bus.move_tick && (r_cnt != '0);
  assign w_push = w_arrow
               && (w_d != r_tail)
               && (w_d != (r_tail ^ 2'b01))
               && (!w_full || w_pop);
  assign w_drop = w_arrow && !w_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= 2'b00;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_tail  <= 2'b00;
      r_dir   <= 2'b00;
      r_start <= 1'b0;
      r_pause <= 1'b0;
      r_drop  <= 1'b0;
    end else if (bus.init) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_tail  <= 2'b00;
      r_dir   <= 2'b00;
      r_start <= 1'b0;
      r_pause <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_start <= w_start;
      r_pause <= w_pause;
      r_drop  <= w_drop;
      if (w_push) begin
        r_q[r_wp] <= w_d;
        r_wp      <= r_wp + AW'(1);
        r_tail    <= w_d;
      end
      if (w_pop) begin
        r_dir <= r_q[r_rp];
        r_rp  <= r_rp + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign bus.dir         = r_dir;
  assign bus.turn_count  = r_cnt;
  assign bus.start_pulse = r_start;
  assign bus.pause_pulse = r_pause;
  assign bus.drop_pulse  = r_drop;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed vectors feed a scoreboard queue;
// a negedge monitor pops and compares the registered outputs.
module tb_snake_dir_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  snake_dir_ctrl_if #(.CW(2)) bus ();

  snake_dir_ctrl #(
    .DEPTH(2),
    .CW   (2)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] dir;
    logic [1:0] cnt;
    logic       s;
    logic       p;
    logic       d;
  } obs_t;

  typedef struct {
    int    due;
    obs_t  exp;
    string name;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    n_run = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  item_t m_it;
  obs_t  m_act;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      m_it  = sb.pop_front();
      m_act = {bus.dir, bus.turn_count, bus.start_pulse,
               bus.pause_pulse, bus.drop_pulse};
      n_run++;
      if (m_act !== m_it.exp) begin
        n_fail++;
        $display("FAIL %s: got dir/cnt/s/p/d=%b required %b",
                 m_it.name, m_act, m_it.exp);
      end
    end
  end

  task automatic tv(input logic kv, input logic [7:0] kc,
                    input logic mt, input logic ini,
                    input logic [1:0] ed, input logic [1:0] ec,
                    input logic es, input logic ep, input logic edr,
                    input string nm);
    item_t it;
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.move_tick = mt;
    bus.init      = ini;
    it.due  = cyc + 1;
    it.exp  = {ed, ec, es, ep, edr};
    it.name = nm;
    sb.push_back(it);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    bus.move_tick = 1'b0;
    bus.init      = 1'b0;
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    bus.move_tick = 1'b0;
    bus.init      = 1'b0;
    #2;
    n_run++;
    if ({bus.dir, bus.turn_count, bus.start_pulse,
         bus.pause_pulse, bus.drop_pulse} !== 7'b0) begin
      n_fail++;
      $display("FAIL in_reset: got %b%b required 0",
               bus.dir, bus.turn_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    tv(0, 8'h00, 0, 0, 2'b00, 2'd0, 0, 0, 0, "post_reset");

    // extended up, then tick
    tv(1, 8'hE0, 0, 0, 2'b00, 2'd0, 0, 0, 0, "e0");
    tv(1, 8'h75, 0, 0, 2'b00, 2'd1, 0, 0, 0, "e0_75_push");
    tv(0, 8'h00, 1, 0, 2'b11, 2'd0, 0, 0, 0, "tick_up");

    // reversal rejected
    tv(0, 8'h00, 0, 1, 2'b00, 2'd0, 0, 0, 0, "init1");
    tv(1, 8'h6B, 0, 0, 2'b00, 2'd0, 0, 0, 1, "rev_drop");
    tv(0, 8'h00, 1, 0, 2'b00, 2'd0, 0, 0, 0, "rev_tick");
    tv(0, 8'h00, 1, 0, 2'b00, 2'd0, 0, 0, 0, "rev_tick2");

    // right->up->left via tail_dir
    tv(1, 8'h75, 0, 0, 2'b00, 2'd1, 0, 0, 0, "q_up");
    tv(1, 8'h6B, 0, 0, 2'b00, 2'd2, 0, 0, 0, "q_left");
    tv(0, 8'h00, 1, 0, 2'b11, 2'd1, 0, 0, 0, "pop_up");
    tv(0, 8'h00, 1, 0, 2'b01, 2'd0, 0, 0, 0, "pop_left");

    // full queue: drop, then accept with pop
    tv(1, 8'h75, 0, 0, 2'b01, 2'd1, 0, 0, 0, "f_up");
    tv(1, 8'h74, 0, 0, 2'b01, 2'd2, 0, 0, 0, "f_right");
    tv(1, 8'h72, 0, 0, 2'b01, 2'd2, 0, 0, 1, "full_drop");
    tv(1, 8'h72, 1, 0, 2'b11, 2'd2, 0, 0, 0, "full_pop_push");
    tv(0, 8'h00, 1, 0, 2'b00, 2'd1, 0, 0, 0, "pop_right");
    tv(0, 8'h00, 1, 0, 2'b10, 2'd0, 0, 0, 0, "pop_down");
    tv(0, 8'h00, 1, 0, 2'b10, 2'd0, 0, 0, 0, "empty_tick");

    // break sequences ignored, start/pause decoded
    tv(1, 8'hE0, 0, 0, 2'b10, 2'd0, 0, 0, 0, "brk_e0");
    tv(1, 8'hF0, 0, 0, 2'b10, 2'd0, 0, 0, 0, "brk_f0");
    tv(1, 8'h75, 0, 0, 2'b10, 2'd0, 0, 0, 0, "ebrk_75");
    tv(1, 8'hF0, 0, 0, 2'b10, 2'd0, 0, 0, 0, "brk2_f0");
    tv(1, 8'h5A, 0, 0, 2'b10, 2'd0, 0, 0, 0, "brk2_5a");
    tv(1, 8'h5A, 0, 0, 2'b10, 2'd0, 1, 0, 0, "start");
    tv(0, 8'h00, 0, 0, 2'b10, 2'd0, 0, 0, 0, "start_end");
    tv(1, 8'h29, 0, 0, 2'b10, 2'd0, 0, 1, 0, "pause");
    tv(1, 8'hE0, 0, 0, 2'b10, 2'd0, 0, 0, 0, "ext_e0");
    tv(1, 8'h5A, 0, 0, 2'b10, 2'd0, 1, 0, 0, "ext_start");

    // init beats tick and key
    tv(1, 8'h74, 0, 0, 2'b10, 2'd1, 0, 0, 0, "i_right");
    tv(1, 8'h75, 0, 0, 2'b10, 2'd2, 0, 0, 0, "i_up");
    tv(1, 8'h29, 1, 1, 2'b00, 2'd0, 0, 0, 0, "init_prio");
    tv(1, 8'h75, 0, 0, 2'b00, 2'd1, 0, 0, 0, "after_init");
    tv(0, 8'h00, 1, 0, 2'b11, 2'd0, 0, 0, 0, "ai_tick");
    tv(1, 8'h75, 0, 0, 2'b11, 2'd0, 0, 0, 1, "typematic");
    tv(1, 8'h74, 0, 0, 2'b11, 2'd1, 0, 0, 0, "pre_rst");

    // asynchronous reset mid-cycle
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({bus.dir, bus.turn_count} !== 4'b0) begin
      n_fail++;
      $display("FAIL async_rst: got %b%b required 0000",
               bus.dir, bus.turn_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tv(0, 8'h00, 1, 0, 2'b00, 2'd0, 0, 0, 0, "post_async");

    repeat (3) @(posedge clk);
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
